crc_engine_mc: RTL
==================

Name: crc_engine_mc

Overview:
- Parametrised multi-cycle CRC engine for the FEC datapath, generalising the fixed CRC0 (56b data / CRC-8) and CRC1 (12b data / CRC-4) configurations into one block.
- Processes BITS_PER_CYCLE message bits per clock.
- Supports two modes:
  - generate: compute the CRC to append before the encoder.
  - check: recompute the CRC and compare it against a received CRC on the UL path.
- One instance per CRC channel; driven by the command/serializer control logic.

Parameters:
- DATA_WIDTH, 56: message width in bits.
- CRC_WIDTH, 8: CRC width in bits.
- POLY, 9'h107: generator polynomial, CRC_WIDTH+1 bits, explicit MSB. Only bits [CRC_WIDTH-1:0] are used in the XOR.
- SEED, 0: initial remainder, CRC_WIDTH bits.
- BITS_PER_CYCLE, 8: message bits consumed per clock. DATA_WIDTH % BITS_PER_CYCLE must be 0; a violation is an elaboration-time fatal error.
- Derived: NCYC = DATA_WIDTH/BITS_PER_CYCLE; CNT_W = $clog2(NCYC+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- mode_i  in  1  0 = generate, 1 = check; captured with start_i
- abort_i  in  1  synchronous abort; returns the engine to IDLE
- data_i  in  DATA_WIDTH  message, MSB transmitted first; captured with start_i
- crc_i  in  CRC_WIDTH  received CRC for check mode; captured with start_i
- busy_o  out  1  high while computing
- done_o  out  1  one-cycle completion pulse
- crc_o  out  CRC_WIDTH  computed CRC
- crc_err_o  out  1  check mode: computed CRC != captured crc_i; 0 in generate mode

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy_o, done_o, crc_err_o = 0; crc_o = 0; internal shift register, remainder and counter = 0.
- Algorithm: non-reflected, MSB-first, no final XOR. For each bit d:
  - fb = rem[CRC_WIDTH-1] ^ d
  - rem = {rem[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY[CRC_WIDTH-1:0] : 0)
  - BITS_PER_CYCLE such steps are unrolled combinationally per clock.
- States:
  - IDLE:
    - On start_i=1 at edge E0: capture data_i, mode_i, crc_i; rem <= SEED; counter <= 0; go to CALC; busy_o <= 1.
    - start_i=0: hold.
  - CALC:
    - Each edge consumes the top BITS_PER_CYCLE bits of the shift register, then shifts left by BITS_PER_CYCLE.
    - counter increments each edge.
    - On the edge where counter reaches NCYC-1 (edge E_NCYC): go to IDLE; busy_o <= 0; done_o <= 1; crc_o <= final rem; crc_err_o <= mode ? (final rem != captured crc_i) : 0.
- Latency: done_o is high in the cycle following E_NCYC, i.e. NCYC clocks after the start-sampling edge. Defaults give 7 clocks.
- done_o is high for exactly one cycle.
- crc_o and crc_err_o hold their values until the next completion. They are not cleared by start or abort.
- start_i while busy: ignored. Inputs are not re-captured; no error is flagged.
- Back-to-back operation: start_i=1 in the cycle where done_o=1 is accepted (state is IDLE). The new run starts on that edge and done_o falls the next cycle.
- abort_i:
  - In CALC: next state IDLE, busy_o <= 0; no done_o; crc_o and crc_err_o unchanged.
  - abort_i has priority over completion on the same edge.
  - abort_i and start_i together in IDLE: abort wins; start is not accepted.
- Reset mid-CALC: immediate return to reset values. No done_o is produced.
- The counter never wraps. NCYC=1 is legal: done_o is high one clock after start.

Test Plan:
- Defaults, generate mode, data_i=56'h1, start pulse -> busy_o high for 7 cycles; done_o pulse 7 clocks after start; crc_o=8'h07; crc_err_o=0.
- Defaults, data_i=56'h80 -> crc_o=8'h89. Data_i=0 -> crc_o=8'h00.
- Defaults, check mode, data_i=56'h1:
  - crc_i=8'h07 -> crc_err_o=0.
  - Repeat with crc_i=8'h06 -> crc_err_o=1, crc_o=8'h07.
- CRC1 configuration (DATA_WIDTH=12, CRC_WIDTH=4, POLY=5'b10011, BITS_PER_CYCLE=4), data_i=12'h001 -> done_o 3 clocks after start; crc_o=4'h3.
- Sequencing:
  - start_i pulsed at cycle 3 of a run -> ignored; single done_o; result matches the first data.
  - start_i asserted in the done_o cycle -> second run completes 7 clocks later with the correct CRC.
- Abort and reset:
  - abort_i at cycle 4 of CALC -> busy_o low next cycle; no done_o; crc_o keeps its previous value.
  - rst_n low mid-CALC -> all outputs 0 immediately; no done_o after release.

Source files
------------

// File: rtl/crc_engine_mc.sv
// Multi-cycle CRC engine: MSB-first, non-reflected, no final XOR, BITS_PER_CYCLE
// message bits folded into the remainder each clock. Generate or check mode.
module crc_engine_mc #(
  parameter int                   DATA_WIDTH     = 56,
  parameter int                   CRC_WIDTH      = 8,
  parameter logic [CRC_WIDTH:0]   POLY           = 9'h107,
  parameter logic [CRC_WIDTH-1:0] SEED           = '0,
  parameter int                   BITS_PER_CYCLE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CRC_WIDTH-1:0]  crc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CRC_WIDTH-1:0]  crc_o,
  output logic                  crc_err_o
);

  localparam int NCYC  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(NCYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $fatal(1, "crc_engine_mc: DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_CALC = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CRC_WIDTH-1:0]  rem_q, rem_d;
  logic                  mode_q, mode_d;
  logic [CRC_WIDTH-1:0]  crci_q, crci_d;
  logic                  done_q, done_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic                  err_q, err_d;
  logic [CRC_WIDTH-1:0]  rem_step;
  logic                  fb;

  // One clock's worth of serial CRC steps, taken from the top of the shift register.
  always_comb begin
    rem_step = rem_q;
    fb       = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      fb       = rem_step[CRC_WIDTH-1] ^ sh_q[DATA_WIDTH-1-i];
      rem_step = (rem_step << 1) ^ (fb ? POLY[CRC_WIDTH-1:0] : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      crci_q  <= '0;
      done_q  <= 1'b0;
      crc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      crci_q  <= crci_d;
      done_q  <= done_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  // Abort beats both start (in IDLE) and completion (in CALC).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    crci_d  = crci_q;
    done_d  = 1'b0;
    crc_d   = crc_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_CALC;
          sh_d    = data_i;
          mode_d  = mode_i;
          crci_d  = crc_i;
          rem_d   = SEED;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          sh_d  = sh_q << BITS_PER_CYCLE;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            crc_d   = rem_step;
            err_d   = mode_q && (rem_step != crci_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == ST_CALC);
    done_o    = done_q;
    crc_o     = crc_q;
    crc_err_o = err_q;
  end

endmodule
